// File: rtl/decoder_2_to_4_queued.sv
// decoder_2_to_4_queued
//   Receive side of the 4-to-2 encoder link. Accepts 2-bit codes over a valid/ready
//   handshake and buffers them in a DEPTH-entry FIFO. Each code is then replayed as a
//   one-hot value on out_lines, held for HOLD_CYCLES clocks. Back-to-back codes are
//   replayed with no idle gap between them.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   in_lines    2-bit code to queue
//   in_valid    in_lines carries a valid code this cycle
//   in_ready    a code can be accepted this cycle (low during reset or when full)
//   out_lines   one-hot decoded lines, 4'b0000 when idle
//   out_active  high while any out_lines bit is set
//   fifo_level  number of queued codes, 0..DEPTH
module decoder_2_to_4_queued #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 in_lines,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [3:0]                 out_lines,
  output logic                       out_active,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam int unsigned TimerW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [LevelW-1:0] LevelFull = LevelW'(DEPTH);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        out_q, out_d;
  logic [1:0]        head_code;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // Ready depends only on registered level (and reset); a same-cycle pop never
  // frees a slot early, so there is no full-FIFO pass-through path.
  assign in_ready   = !rst && (level_q != LevelFull);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (level_q == '0);
  assign head_code  = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    out_d   = out_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          out_d   = 4'b0001 << head_code;
          timer_d = TimerLoad;
          state_d = StHold;
        end
      end
      StHold: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (!fifo_empty) begin
          // Chain straight into the next code without an idle cycle.
          pop     = 1'b1;
          out_d   = 4'b0001 << head_code;
          timer_d = TimerLoad;
        end else begin
          out_d   = 4'b0000;
          state_d = StIdle;
        end
      end
      default: begin
        out_d   = 4'b0000;
        state_d = StIdle;
      end
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      timer_q  <= '0;
      out_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      timer_q  <= timer_d;
      out_q    <= out_d;
    end
  end

  // Storage needs no reset: entries are only read once the level says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_lines;
    end
  end

  assign out_lines  = out_q;
  assign out_active = |out_q;
  assign fifo_level = level_q;

endmodule
